// File: rtl/car_frame_collector.sv
// car_frame_collector: gathers wheel/body/COM beats into shadow buffers and
// commits a whole frame to the outputs only when every stream is exactly full.
module car_frame_stream #(
  parameter int W = 17,
  parameter int N = 4
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic signed [W-1:0] x,
  input  logic signed [W-1:0] y,
  input  logic                valid,
  input  logic                all_done,
  input  logic                commit,
  output logic                good,
  output logic signed [W-1:0] out_x [N],
  output logic signed [W-1:0] out_y [N]
);
  localparam int IW = N > 1 ? $clog2(N) : 1;
  localparam int CW = $clog2(N + 2);
  logic [IW-1:0] idx;
  logic [CW-1:0] cnt, cnt_next;
  logic signed [W-1:0] sh_x [N], sh_y [N], nx_x [N], nx_y [N];
  // nx_* folds in a beat landing with all_done so it reaches the commit
  always_comb begin
    nx_x = sh_x;
    nx_y = sh_y;
    if (valid) begin
      nx_x[idx] = x;
      nx_y[idx] = y;
    end
    cnt_next = (valid && cnt != CW'(N + 1)) ? cnt + 1'b1 : cnt;
    good = cnt_next == CW'(N);
  end
  always_ff @(posedge clk_in or negedge rst_in)
    if (!rst_in) begin
      idx   <= '0;
      cnt   <= '0;
      sh_x  <= '{default: '0};
      sh_y  <= '{default: '0};
      out_x <= '{default: '0};
      out_y <= '{default: '0};
    end else begin
      sh_x <= nx_x;
      sh_y <= nx_y;
      idx  <= all_done ? '0 : valid ? (idx == IW'(N - 1) ? '0 : idx + 1'b1) : idx;
      cnt  <= all_done ? '0 : cnt_next;
      if (commit) begin
        out_x <= nx_x;
        out_y <= nx_y;
      end
    end
endmodule

module car_frame_collector #(
  parameter int POSITION_SIZE   = 17,
  parameter int NUM_WHEEL_NODES = 4,
  parameter int NUM_BODY_NODES  = 3
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic signed [POSITION_SIZE-1:0] left_wheel_x,
  input  logic signed [POSITION_SIZE-1:0] left_wheel_y,
  input  logic                            left_wheel_valid,
  input  logic signed [POSITION_SIZE-1:0] right_wheel_x,
  input  logic signed [POSITION_SIZE-1:0] right_wheel_y,
  input  logic                            right_wheel_valid,
  input  logic signed [POSITION_SIZE-1:0] body_x,
  input  logic signed [POSITION_SIZE-1:0] body_y,
  input  logic                            body_valid,
  input  logic        [POSITION_SIZE-1:0] com_x_in,
  input  logic        [POSITION_SIZE-1:0] com_y_in,
  input  logic                            com_valid,
  input  logic                            all_done,
  input  logic                            clear_error,
  output logic signed [POSITION_SIZE-1:0] car_wheel_1_x [NUM_WHEEL_NODES],
  output logic signed [POSITION_SIZE-1:0] car_wheel_1_y [NUM_WHEEL_NODES],
  output logic signed [POSITION_SIZE-1:0] car_wheel_2_x [NUM_WHEEL_NODES],
  output logic signed [POSITION_SIZE-1:0] car_wheel_2_y [NUM_WHEEL_NODES],
  output logic signed [POSITION_SIZE-1:0] car_body_x    [NUM_BODY_NODES],
  output logic signed [POSITION_SIZE-1:0] car_body_y    [NUM_BODY_NODES],
  output logic        [POSITION_SIZE-1:0] camera_x,
  output logic        [POSITION_SIZE-1:0] camera_y,
  output logic                            frame_valid,
  output logic        [15:0]              frame_count,
  output logic                            stream_error,
  output logic                            busy
);
  typedef enum logic {IDLE, COLLECT} state_t;
  state_t state, state_next;
  logic good_l, good_r, good_b, commit, com_seen;
  logic [POSITION_SIZE-1:0] com_x, com_y;
  assign commit = all_done & good_l & good_r & good_b;
  assign busy = state == COLLECT;
  car_frame_stream #(.W(POSITION_SIZE), .N(NUM_WHEEL_NODES)) u_left (
    .clk_in, .rst_in, .x(left_wheel_x), .y(left_wheel_y), .valid(left_wheel_valid),
    .all_done, .commit, .good(good_l), .out_x(car_wheel_1_x), .out_y(car_wheel_1_y)
  );
  car_frame_stream #(.W(POSITION_SIZE), .N(NUM_WHEEL_NODES)) u_right (
    .clk_in, .rst_in, .x(right_wheel_x), .y(right_wheel_y), .valid(right_wheel_valid),
    .all_done, .commit, .good(good_r), .out_x(car_wheel_2_x), .out_y(car_wheel_2_y)
  );
  car_frame_stream #(.W(POSITION_SIZE), .N(NUM_BODY_NODES)) u_body (
    .clk_in, .rst_in, .x(body_x), .y(body_y), .valid(body_valid),
    .all_done, .commit, .good(good_b), .out_x(car_body_x), .out_y(car_body_y)
  );
  always_comb begin
    state_next = state;
    if (all_done) state_next = IDLE;
    else if (left_wheel_valid || right_wheel_valid || body_valid) state_next = COLLECT;
  end
  always_ff @(posedge clk_in or negedge rst_in)
    if (!rst_in) state <= IDLE;
    else state <= state_next;
  always_ff @(posedge clk_in or negedge rst_in)
    if (!rst_in) begin
      com_x        <= '0;
      com_y        <= '0;
      com_seen     <= 1'b0;
      camera_x     <= '0;
      camera_y     <= '0;
      frame_valid  <= 1'b0;
      frame_count  <= '0;
      stream_error <= 1'b0;
    end else begin
      if (com_valid) begin
        com_x <= com_x_in;
        com_y <= com_y_in;
      end
      com_seen <= all_done ? 1'b0 : com_seen | com_valid;
      // a frame without COM leaves the camera where it was
      if (commit && (com_seen || com_valid)) begin
        camera_x <= com_valid ? com_x_in : com_x;
        camera_y <= com_valid ? com_y_in : com_y;
      end
      frame_valid  <= commit;
      frame_count  <= commit ? frame_count + 1'b1 : frame_count;
      stream_error <= (all_done && !commit) ? 1'b1 : clear_error ? 1'b0 : stream_error;
    end
endmodule
